// File: rtl/mdio_master.sv
// MDIO (IEEE 802.3 Clause 22/45) management master.
// Define MDIO_CL45_EN to let cl45 select the Clause 45 start code.
module mdio_master #(
  parameter int CLK_DIV = 4,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        cl45,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  input  logic [1:0]  op,
  input  logic        start,
  output logic        ready,
  output logic [15:0] rdata,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST = 6'(PRE_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic        mdc_q, mdc_d;
  logic        mdo_q, mdo_d;
  logic        oe_q, oe_d;
  logic        rd_q, rd_d;
  logic        fin_q, fin_d;
  logic [31:0] sh_q, sh_d;
  logic [15:0] rsh_q, rsh_d;
  logic        ta_err_q, ta_err_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;

  logic        busy;
  logic        tick;
  logic        rise;
  logic        fall;
  logic        pop;
  logic [1:0]  st;
  logic [31:0] frame;

`ifdef MDIO_CL45_EN
  assign st = cl45 ? 2'b00 : 2'b01;
`else
  logic unused_cl45;
  assign unused_cl45 = cl45;
  assign st = 2'b01;
`endif

  // Reads keep the line released from TA onward, so their tail bits are
  // don't-care ones.
  assign frame = {st, op, phy_addr, reg_addr,
                  op[1] ? 2'b11 : 2'b10,
                  op[1] ? 16'hffff : wdata};

  assign busy = (state_q != IDLE) && !fin_q;
  assign tick = busy && (div_q == DIV_LAST);
  assign rise = tick && !mdc_q;
  assign fall = tick && mdc_q;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    mdc_d    = mdc_q;
    mdo_d    = mdo_q;
    oe_d     = oe_q;
    rd_d     = rd_q;
    fin_d    = fin_q;
    sh_d     = sh_q;
    rsh_d    = rsh_q;
    ta_err_d = ta_err_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ready_d  = ready_q;
    pop      = 1'b0;

    if (state_q == IDLE) begin
      div_d = '0;
      bit_d = '0;
      mdc_d = 1'b0;
      mdo_d = 1'b1;
      oe_d  = 1'b0;
      fin_d = 1'b0;
      if (start) begin
        rd_d     = op[1];
        oe_d     = 1'b1;
        ready_d  = 1'b0;
        ta_err_d = 1'b0;
        rsh_d    = '0;
        if (PRE_LEN > 0) begin
          state_d = PRE;
          sh_d    = frame;
        end else begin
          state_d = HDR;
          mdo_d   = frame[31];
          sh_d    = {frame[30:0], 1'b0};
        end
      end
    end else if (fin_q) begin
      state_d = IDLE;
      fin_d   = 1'b0;
      div_d   = '0;
      ready_d = 1'b1;
      if (rd_q) begin
        rdata_d = rsh_q;
        err_d   = ta_err_q;
      end else begin
        err_d = 1'b0;
      end
    end else begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
      if (tick) mdc_d = !mdc_q;
      if (rise) begin
        if (state_q == TA && bit_q == 6'd1) ta_err_d = mdio_i;
        if (state_q == DATA) rsh_d = {rsh_q[14:0], mdio_i};
      end
      if (fall) begin
        bit_d = bit_q + 6'd1;
        pop   = 1'b1;
        unique case (state_q)
          PRE: begin
            if (bit_q == PRE_LAST) begin
              state_d = HDR;
              bit_d   = '0;
            end else begin
              pop = 1'b0;
            end
          end
          HDR: begin
            if (bit_q == 6'd13) begin
              state_d = TA;
              bit_d   = '0;
              if (rd_q) oe_d = 1'b0;
            end
          end
          TA: begin
            if (bit_q == 6'd1) begin
              state_d = DATA;
              bit_d   = '0;
            end
          end
          DATA: begin
            if (bit_q == 6'd15) begin
              fin_d = 1'b1;
              bit_d = '0;
              pop   = 1'b0;
              mdo_d = 1'b1;
              oe_d  = 1'b0;
            end
          end
          default: ;
        endcase
        if (pop) begin
          mdo_d = sh_q[31];
          sh_d  = {sh_q[30:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      mdc_q    <= 1'b0;
      mdo_q    <= 1'b1;
      oe_q     <= 1'b0;
      rd_q     <= 1'b0;
      fin_q    <= 1'b0;
      sh_q     <= '0;
      rsh_q    <= '0;
      ta_err_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      mdc_q    <= mdc_d;
      mdo_q    <= mdo_d;
      oe_q     <= oe_d;
      rd_q     <= rd_d;
      fin_q    <= fin_d;
      sh_q     <= sh_d;
      rsh_q    <= rsh_d;
      ta_err_q <= ta_err_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign mdc     = mdc_q;
  assign mdio_o  = mdo_q;
  assign mdio_oe = oe_q;
  assign ready   = ready_q;
  assign rdata   = rdata_q;
  assign error   = err_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: frame capture on mdc rise,
// simple PHY responder, reset and preamble-less instance.
module tb_mdio_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc, mdio_i, mdio_o, mdio_oe;
  logic        cl45;
  logic [4:0]  phy_addr, reg_addr;
  logic [15:0] wdata;
  logic [1:0]  op;
  logic        start, start0;
  logic        ready;
  logic [15:0] rdata;
  logic        error;

  logic        mdc0, mdio_o0, mdio_oe0, ready0, error0;
  logic        mdio_i0;
  logic [15:0] rdata0;

  int checks = 0;
  int errors = 0;

  logic [63:0] phy_vec;
  logic [63:0] cap_vec, oe_vec;
  int          cap_n;
  logic [31:0] cap0_vec;
  int          cap0_n;

`ifdef MDIO_CL45_EN
  localparam logic [1:0] ST45 = 2'b00;
`else
  localparam logic [1:0] ST45 = 2'b01;
`endif

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(4), .PRE_LEN(32)) dut (
    .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .cl45(cl45),
    .phy_addr(phy_addr), .reg_addr(reg_addr), .wdata(wdata),
    .op(op), .start(start), .ready(ready), .rdata(rdata),
    .error(error)
  );

  mdio_master #(.CLK_DIV(2), .PRE_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .mdc(mdc0), .mdio_i(mdio_i0),
    .mdio_o(mdio_o0), .mdio_oe(mdio_oe0), .cl45(cl45),
    .phy_addr(phy_addr), .reg_addr(reg_addr), .wdata(wdata),
    .op(op), .start(start0), .ready(ready0), .rdata(rdata0),
    .error(error0)
  );

  assign mdio_i = (cap_n < 64) ? phy_vec[63 - cap_n] : 1'b1;
  assign mdio_i0 = 1'b1;

  always @(posedge mdc) begin
    cap_vec = {cap_vec[62:0], mdio_o};
    oe_vec  = {oe_vec[62:0], mdio_oe};
    cap_n   = cap_n + 1;
  end

  always @(posedge mdc0) begin
    cap0_vec = {cap0_vec[30:0], mdio_o0};
    cap0_n   = cap0_n + 1;
  end

  task automatic run_main(input logic c, input logic [1:0] o,
                          input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, input logic glitch,
                          output int cyc);
    @(negedge clk);
    cl45 = c; op = o; phy_addr = pa; reg_addr = ra; wdata = wd;
    cap_n = 0; cap_vec = '0; oe_vec = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_low got %b want 0", ready);
    end
    cyc = 0;
    while (ready !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      if (glitch && cyc == 100) begin
        start = 1'b1; op = 2'b11; phy_addr = 5'h1f; wdata = 16'h0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL ready_timeout got %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start0 = 1'b0; cl45 = 1'b0;
    op = 2'b00; phy_addr = '0; reg_addr = '0; wdata = '0;
    phy_vec = '1; cap_n = 0; cap0_n = 0;
    #22;
    checks++;
    if ({mdc, mdio_o, mdio_oe, ready, error} !== 5'b01010) begin
      errors++;
      $display("FAIL reset_ctl got %b want 01010",
               {mdc, mdio_o, mdio_oe, ready, error});
    end
    checks++;
    if (rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h want 0000", rdata);
    end
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 checks++;
    if ({mdc, mdio_o, mdio_oe, ready} !== 4'b0101) begin
      errors++;
      $display("FAIL idle_ctl got %b want 0101",
               {mdc, mdio_o, mdio_oe, ready});
    end
  endtask

  task automatic test_write();
    int cyc;
    run_main(1'b0, 2'b01, 5'd0, 5'd1, 16'h55aa, 1'b0, cyc);
    checks++;
    if (cyc !== 513) begin
      errors++;
      $display("FAIL wr_latency got %0d want 513", cyc);
    end
    checks++;
    if (cap_vec !== {32'hffffffff, 2'b01, 2'b01, 5'd0, 5'd1,
                     2'b10, 16'h55aa}) begin
      errors++;
      $display("FAIL wr_frame got %h", cap_vec);
    end
    checks++;
    if (oe_vec !== 64'hffffffffffffffff || cap_n !== 64) begin
      errors++;
      $display("FAIL wr_oe got %h n %0d want all ones n 64",
               oe_vec, cap_n);
    end
    checks++;
    if ({mdio_oe, mdio_o, mdc, error} !== 4'b0100) begin
      errors++;
      $display("FAIL wr_idle got %b want 0100",
               {mdio_oe, mdio_o, mdc, error});
    end
  endtask

  task automatic test_read();
    int cyc;
    phy_vec = {{46{1'b1}}, 1'b1, 1'b0, 16'h1234};
    run_main(1'b0, 2'b10, 5'd1, 5'd16, 16'h0, 1'b0, cyc);
    checks++;
    if (rdata !== 16'h1234 || error !== 1'b0) begin
      errors++;
      $display("FAIL rd_data got %h err %b want 1234 err 0",
               rdata, error);
    end
    checks++;
    if (cap_vec[63:18] !== {32'hffffffff, 2'b01, 2'b10, 5'd1, 5'd16}) begin
      errors++;
      $display("FAIL rd_hdr got %h", cap_vec[63:18]);
    end
    checks++;
    if (oe_vec !== {{46{1'b1}}, 18'h0}) begin
      errors++;
      $display("FAIL rd_oe got %h", oe_vec);
    end
    checks++;
    if (cyc !== 513) begin
      errors++;
      $display("FAIL rd_latency got %0d want 513", cyc);
    end
  endtask

  task automatic test_no_phy();
    int cyc;
    phy_vec = '1;
    run_main(1'b0, 2'b11, 5'd7, 5'd2, 16'h0, 1'b0, cyc);
    checks++;
    if (rdata !== 16'hffff || error !== 1'b1) begin
      errors++;
      $display("FAIL nophy got %h err %b want ffff err 1",
               rdata, error);
    end
  endtask

  task automatic test_cl45_glitch();
    int cyc;
    run_main(1'b1, 2'b00, 5'd2, 5'd3, 16'ha5a5, 1'b1, cyc);
    checks++;
    if (cap_vec !== {32'hffffffff, ST45, 2'b00, 5'd2, 5'd3,
                     2'b10, 16'ha5a5}) begin
      errors++;
      $display("FAIL cl45_frame got %h", cap_vec);
    end
    checks++;
    if (cyc !== 513) begin
      errors++;
      $display("FAIL cl45_latency got %0d want 513", cyc);
    end
    checks++;
    if (error !== 1'b0 || rdata !== 16'hffff) begin
      errors++;
      $display("FAIL wr_clears_err got %h err %b want ffff err 0",
               rdata, error);
    end
    repeat (20) @(posedge clk);
    #1 checks++;
    if (ready !== 1'b1 || cap_n !== 64) begin
      errors++;
      $display("FAIL glitch_idle got ready %b n %0d want 1 64",
               ready, cap_n);
    end
  endtask

  task automatic test_no_preamble();
    int cyc;
    @(negedge clk);
    cl45 = 1'b0; op = 2'b01; phy_addr = 5'd3; reg_addr = 5'd7;
    wdata = 16'hbeef; cap0_n = 0; cap0_vec = '0;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    cyc = 0;
    while (ready0 !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (cyc !== 129) begin
      errors++;
      $display("FAIL pre0_latency got %0d want 129", cyc);
    end
    checks++;
    if (cap0_vec !== {2'b01, 2'b01, 5'd3, 5'd7, 2'b10, 16'hbeef}
        || cap0_n !== 32) begin
      errors++;
      $display("FAIL pre0_frame got %h n %0d", cap0_vec, cap0_n);
    end
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    phy_vec = {{46{1'b1}}, 1'b1, 1'b0, 16'h1234};
    @(negedge clk);
    op = 2'b10; phy_addr = 5'd1; reg_addr = 5'd4;
    cap_n = 0; cap_vec = '0; oe_vec = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cap_n < 52 && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (cap_n < 52) begin
      errors++;
      $display("FAIL rst_reach_data got %0d rises want 52", cap_n);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1 checks++;
    if ({mdc, mdio_o, mdio_oe, ready, error} !== 5'b01010
        || rdata !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid got %b rdata %h want 01010 0000",
               {mdc, mdio_o, mdio_oe, ready, error}, rdata);
    end
    @(negedge clk) rst = 1'b0;
    phy_vec = {{46{1'b1}}, 1'b1, 1'b0, 16'hbeef};
    run_main(1'b0, 2'b10, 5'd1, 5'd4, 16'h0, 1'b0, cyc);
    checks++;
    if (rdata !== 16'hbeef || error !== 1'b0 || cyc !== 513) begin
      errors++;
      $display("FAIL rst_after got %h err %b cyc %0d want beef 0 513",
               rdata, error, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_no_phy();
    test_cl45_glitch();
    test_no_preamble();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
